gray_rd_arbiter: RTL and testbench

Two-client arbiter sharing the single gray-image memory read port (`gray_addr`/`gray_req`/`gray_ready`/`gray_data`) between two LBP window engines.
- Grants tenures round-robin, with a burst cap sized for one 3x3 window fetch.
- Routes each one-cycle-latency read return to the client that issued it.
- Sits between the engines and the testbench/host image memory.

---
 rtl/lbp_pkg.sv | 14 +
 rtl/rr_pick2.sv | 17 +
 rtl/gray_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_gray_rd_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and FSM state encoding for the LBP gray-image read path.
package lbp_pkg;

    localparam int GRAY_ADDR_W    = 14;
    localparam int GRAY_DATA_W    = 8;
    localparam int BURST_MAX_DFLT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: prio_i breaks the tie when both clients request.
module rr_pick2
    import lbp_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio_i,
    output logic win_o,
    output logic any_o
);

    always_comb begin
        any_o = req0_i | req1_i;
        win_o = (req0_i && req1_i) ? prio_i : req1_i;
    end

endmodule

// File: rtl/gray_rd_arbiter.sv
// Shares the single gray-image read port between two LBP window engines,
// round-robin with a per-tenure burst cap, and steers read returns back.
//
// state | meaning
// IDLE  | no owner
// GNT0  | client 0 owns the port
// GNT1  | client 1 owns the port
module gray_rd_arbiter
    import lbp_pkg::*;
#(
    parameter int ADDR_W    = GRAY_ADDR_W,
    parameter int DATA_W    = GRAY_DATA_W,
    parameter int BURST_MAX = BURST_MAX_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_addr,
    output logic              c0_gnt,
    output logic              c1_gnt,
    output logic              c0_rvalid,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_e       state_q, state_d, oth_state;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             inflight_q, owner_q;
    logic             c0_gnt_q, c1_gnt_q;
    logic             pick_win, pick_any;
    logic             own_idx, own_req, oth_req, beat;

    rr_pick2 u_pick (
        .req0_i (c0_req),
        .req1_i (c1_req),
        .prio_i (prio_q),
        .win_o  (pick_win),
        .any_o  (pick_any)
    );

    always_comb begin
        own_idx   = (state_q == GNT1);
        own_req   = own_idx ? c1_req : c0_req;
        oth_req   = own_idx ? c0_req : c1_req;
        oth_state = own_idx ? GNT0 : GNT1;
        beat      = (state_q != IDLE) && own_req && gray_ready;
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gray_ready && pick_any) begin
                    state_d = pick_win ? GNT1 : GNT0;
                end
            end
            GNT0, GNT1: begin
                if (!own_req) begin
                    state_d = oth_req ? oth_state : IDLE;
                    prio_d  = ~own_idx;
                    cnt_d   = '0;
                end else if (beat) begin
                    // Burst cap reached: yield only if the other client is waiting.
                    if (cnt_inc == CNT_W'(BURST_MAX)) begin
                        cnt_d = '0;
                        if (oth_req) begin
                            state_d = oth_state;
                            prio_d  = ~own_idx;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            owner_q    <= 1'b0;
            c0_gnt_q   <= 1'b0;
            c1_gnt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            inflight_q <= beat;
            if (beat) begin
                owner_q <= own_idx;
            end
            c0_gnt_q   <= (state_d == GNT0);
            c1_gnt_q   <= (state_d == GNT1);
        end
    end

    // Returns follow the beat's issuer, even if ownership moved in between.
    always_comb begin
        gray_req  = beat;
        gray_addr = beat ? (own_idx ? c1_addr : c0_addr) : '0;
        c0_gnt    = c0_gnt_q;
        c1_gnt    = c1_gnt_q;
        c0_rvalid = inflight_q && !owner_q;
        c1_rvalid = inflight_q && owner_q;
        c0_rdata  = c0_rvalid ? gray_data : '0;
        c1_rdata  = c1_rvalid ? gray_data : '0;
        busy      = (state_q != IDLE) || inflight_q;
    end

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Self-checking bench for gray_rd_arbiter: per-cycle grant/beat checks and a
// return scoreboard fed by a behavioural one-cycle-latency memory.
module tb_gray_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data = 8'hEE;
    logic        c0_req, c1_req;
    logic [13:0] c0_addr, c1_addr;
    logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [7:0]  c0_rdata, c1_rdata;
    logic        busy;

    typedef struct {
        int         cl;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    gray_rd_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .c0_req     (c0_req),
        .c0_addr    (c0_addr),
        .c1_req     (c1_req),
        .c1_addr    (c1_addr),
        .c0_gnt     (c0_gnt),
        .c1_gnt     (c1_gnt),
        .c0_rvalid  (c0_rvalid),
        .c1_rvalid  (c1_rvalid),
        .c0_rdata   (c0_rdata),
        .c1_rdata   (c1_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [13:0] a);
        return (a[7:0] + {1'b0, a[13:7]}) ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        gray_data <= (gray_req && gray_ready) ? pix(gray_addr) : 8'hEE;
    end

    // Return scoreboard: an entry is due exactly one cycle after its beat.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.cl == 0) ok = (c0_rvalid === 1'b1) && (c1_rvalid === 1'b0) && (c0_rdata === e.data);
            else           ok = (c1_rvalid === 1'b1) && (c0_rvalid === 1'b0) && (c1_rdata === e.data);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL rvalid_route cyc %0d client %0d: got v0=%b d0=%h v1=%b d1=%h, want data %h",
                         cyc, e.cl, c0_rvalid, c0_rdata, c1_rvalid, c1_rdata, e.data);
            end
        end else if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rvalid cyc %0d: got v0=%b v1=%b, want 0 0", cyc, c0_rvalid, c1_rvalid);
        end
        n_cmp++;
        if ((!c0_rvalid && c0_rdata !== 8'h00) || (!c1_rvalid && c1_rdata !== 8'h00)) begin
            n_err++;
            $display("FAIL idle_rdata cyc %0d: got d0=%h d1=%h, want 00 on non-valid client", cyc, c0_rdata, c1_rdata);
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        c0_req = 1'b0;
        c1_req = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; gray_ready = 1'b1; c0_req = 1'b1; c1_req = 1'b1;
        c0_addr = 14'h0011; c1_addr = 14'h0022;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n > 0) begin
                n_cmp++;
                if ({c1_gnt, c0_gnt} !== 2'b00) begin
                    n_err++; $display("FAIL reset_gnt: got %b, want 00", {c1_gnt, c0_gnt});
                end
                n_cmp++;
                if (gray_req !== 1'b0 || gray_addr !== 14'h0) begin
                    n_err++; $display("FAIL reset_req: got req=%b addr=%h, want 0 0000", gray_req, gray_addr);
                end
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++; $display("FAIL reset_busy: got %b, want 0", busy);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int own, b0, b1; logic eb, pb, r0, rdy; logic [13:0] ea;
        do_reset();
        b0 = 0; b1 = 0; pb = 1'b0;
        for (int n = 0; n < 13; n++) begin
            r0  = (n <= 9);
            rdy = 1'b1;
            own = (n >= 1 && n <= 10) ? 0 : -1;
            gray_ready = rdy; c0_req = r0; c1_req = 1'b0;
            c0_addr = 14'h0081 + 14'(b0); c1_addr = 14'h0200;
            eb = (own == 0) && r0 && rdy;
            ea = eb ? c0_addr : 14'h0;
            @(negedge clk);
            n_cmp++;
            if ({c1_gnt, c0_gnt} !== ((own == 0) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL single_gnt cyc %0d: got %b, own %0d", n, {c1_gnt, c0_gnt}, own);
            end
            n_cmp++;
            if (gray_req !== eb || gray_addr !== ea) begin
                n_err++; $display("FAIL single_beat cyc %0d: got %b/%h, want %b/%h", n, gray_req, gray_addr, eb, ea);
            end
            n_cmp++;
            if (busy !== ((own >= 0) || pb)) begin
                n_err++; $display("FAIL single_busy cyc %0d: got %b, want %b", n, busy, (own >= 0) || pb);
            end
            if (eb) begin
                sb.push_back('{cl: 0, data: pix(ea), due: cyc + 1});
                b0++;
            end
            pb = eb;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        int own, b0, b1; logic eb, pb, r, rdy; logic [13:0] ea;
        do_reset();
        b0 = 0; b1 = 0; pb = 1'b0;
        for (int n = 0; n < 22; n++) begin
            r   = (n <= 19);
            rdy = 1'b1;
            if (n >= 1 && n <= 9)        own = 0;
            else if (n >= 10 && n <= 18) own = 1;
            else if (n == 19 || n == 20) own = 0;
            else                         own = -1;
            gray_ready = rdy; c0_req = r; c1_req = r;
            c0_addr = 14'h0100 + 14'(b0); c1_addr = 14'h0200 + 14'(b1);
            eb = (own >= 0) && r && rdy;
            ea = eb ? ((own == 0) ? c0_addr : c1_addr) : 14'h0;
            @(negedge clk);
            n_cmp++;
            if ({c1_gnt, c0_gnt} !== ((own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL cont_gnt cyc %0d: got %b, own %0d", n, {c1_gnt, c0_gnt}, own);
            end
            n_cmp++;
            if (gray_req !== eb || gray_addr !== ea) begin
                n_err++; $display("FAIL cont_beat cyc %0d: got %b/%h, want %b/%h", n, gray_req, gray_addr, eb, ea);
            end
            n_cmp++;
            if (busy !== ((own >= 0) || pb)) begin
                n_err++; $display("FAIL cont_busy cyc %0d: got %b, want %b", n, busy, (own >= 0) || pb);
            end
            if (eb) begin
                sb.push_back('{cl: own, data: pix(ea), due: cyc + 1});
                if (own == 0) b0++; else b1++;
            end
            pb = eb;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int own, b0, b1; logic eb, pb, r, rdy; logic [13:0] ea;
        do_reset();
        b0 = 0; b1 = 0; pb = 1'b0;
        for (int n = 0; n < 16; n++) begin
            r   = (n <= 13);
            rdy = !(n >= 5 && n <= 7);
            if (n >= 1 && n <= 12)       own = 0;
            else if (n == 13 || n == 14) own = 1;
            else                         own = -1;
            gray_ready = rdy; c0_req = r; c1_req = r;
            c0_addr = 14'h0300 + 14'(b0); c1_addr = 14'h0400 + 14'(b1);
            eb = (own >= 0) && r && rdy;
            ea = eb ? ((own == 0) ? c0_addr : c1_addr) : 14'h0;
            @(negedge clk);
            n_cmp++;
            if ({c1_gnt, c0_gnt} !== ((own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL stall_gnt cyc %0d: got %b, own %0d", n, {c1_gnt, c0_gnt}, own);
            end
            n_cmp++;
            if (gray_req !== eb || gray_addr !== ea) begin
                n_err++; $display("FAIL stall_beat cyc %0d: got %b/%h, want %b/%h", n, gray_req, gray_addr, eb, ea);
            end
            n_cmp++;
            if (busy !== ((own >= 0) || pb)) begin
                n_err++; $display("FAIL stall_busy cyc %0d: got %b, want %b", n, busy, (own >= 0) || pb);
            end
            if (eb) begin
                sb.push_back('{cl: own, data: pix(ea), due: cyc + 1});
                if (own == 0) b0++; else b1++;
            end
            pb = eb;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_early_release();
        int own, b0, b1; logic eb, pb, r0, r1, rdy; logic [13:0] ea;
        do_reset();
        b0 = 0; b1 = 0; pb = 1'b0;
        for (int n = 0; n < 17; n++) begin
            r0  = (n <= 14);
            r1  = (n <= 11);
            rdy = 1'b1;
            if (n >= 1 && n <= 9)        own = 0;
            else if (n >= 10 && n <= 12) own = 1;
            else if (n >= 13 && n <= 15) own = 0;
            else                         own = -1;
            gray_ready = rdy; c0_req = r0; c1_req = r1;
            c0_addr = 14'h0500 + 14'(b0); c1_addr = 14'h0600 + 14'(b1);
            eb = ((own == 0) && r0 && rdy) || ((own == 1) && r1 && rdy);
            ea = eb ? ((own == 0) ? c0_addr : c1_addr) : 14'h0;
            @(negedge clk);
            n_cmp++;
            if ({c1_gnt, c0_gnt} !== ((own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL early_gnt cyc %0d: got %b, own %0d", n, {c1_gnt, c0_gnt}, own);
            end
            n_cmp++;
            if (gray_req !== eb || gray_addr !== ea) begin
                n_err++; $display("FAIL early_beat cyc %0d: got %b/%h, want %b/%h", n, gray_req, gray_addr, eb, ea);
            end
            n_cmp++;
            if (busy !== ((own >= 0) || pb)) begin
                n_err++; $display("FAIL early_busy cyc %0d: got %b, want %b", n, busy, (own >= 0) || pb);
            end
            if (eb) begin
                sb.push_back('{cl: own, data: pix(ea), due: cyc + 1});
                if (own == 0) b0++; else b1++;
            end
            pb = eb;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int own, b0, b1; logic eb, pb, r, rdy, rst; logic [13:0] ea;
        do_reset();
        b0 = 0; b1 = 0; pb = 1'b0;
        for (int n = 0; n < 16; n++) begin
            r   = (n <= 13);
            rdy = 1'b1;
            rst = (n == 11);
            if (n >= 1 && n <= 9)        own = 0;
            else if (n == 10 || n == 11) own = 1;
            else if (n == 13 || n == 14) own = 0;
            else                         own = -1;
            reset = rst; gray_ready = rdy; c0_req = r; c1_req = r;
            c0_addr = 14'h0700 + 14'(b0); c1_addr = 14'h0800 + 14'(b1);
            eb = (own >= 0) && r && rdy;
            ea = eb ? ((own == 0) ? c0_addr : c1_addr) : 14'h0;
            @(negedge clk);
            n_cmp++;
            if ({c1_gnt, c0_gnt} !== ((own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL rstmid_gnt cyc %0d: got %b, own %0d", n, {c1_gnt, c0_gnt}, own);
            end
            n_cmp++;
            if (gray_req !== eb || gray_addr !== ea) begin
                n_err++; $display("FAIL rstmid_beat cyc %0d: got %b/%h, want %b/%h", n, gray_req, gray_addr, eb, ea);
            end
            n_cmp++;
            if (busy !== ((own >= 0) || pb)) begin
                n_err++; $display("FAIL rstmid_busy cyc %0d: got %b, want %b", n, busy, (own >= 0) || pb);
            end
            if (eb && !rst) begin
                sb.push_back('{cl: own, data: pix(ea), due: cyc + 1});
            end
            if (eb) begin
                if (own == 0) b0++; else b1++;
            end
            pb = eb && !rst;
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; gray_ready = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
        c0_addr = 14'h0; c1_addr = 14'h0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_early_release();
        test_reset_mid();
        @(posedge clk); #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending returns, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
